// File: rtl/isp_pkg.sv
// isp_pkg: shared declarations for the ISP output selector.
//   tap_state_t        selector state encoding (ST_RUN / ST_ARM / ST_MUTE)
//   TAP_RAW..TAP_ENH   named tap indices of the standard pipeline
//   DEBUG_RGB_DEFAULT  {R,G,B} colour shown for invalid select codes
package isp_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ARM  = 2'd1,
    ST_MUTE = 2'd2
  } tap_state_t;

  localparam int TAP_RAW = 0;
  localparam int TAP_DPC = 1;
  localparam int TAP_BNR = 2;
  localparam int TAP_CFA = 3;
  localparam int TAP_AWB = 4;
  localparam int TAP_CCM = 5;
  localparam int TAP_GMA = 6;
  localparam int TAP_ENH = 7;

  localparam logic [23:0] DEBUG_RGB_DEFAULT = 24'h00FF00;

endpackage

// File: rtl/isp_vsync_edge.sv
// isp_vsync_edge: rising-edge detector for one tap's vsync.
//   clk          pixel clock
//   reset_n      asynchronous, active-low reset
//   vsync        tap vsync, active high
//   frame_start  high in the cycle where vsync is 1 and was 0 on the previous cycle
module isp_vsync_edge
  import isp_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic vsync,
  output logic frame_start
);

  logic vsync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
    end
  end

  // Combinational so the switch can happen on the very edge that sees the rise.
  assign frame_start = vsync & ~vsync_q;

endmodule

// File: rtl/isp_tap_select.sv
// isp_tap_select: frame-synchronous N-tap output selector for the ISP pipeline.
// Source changes take effect only on the new source's frame start, optionally
// followed by MUTE_FRAMES black frames; invalid select codes show DEBUG_RGB.
//   clk, reset_n                  pixel clock, asynchronous active-low reset
//   tap_vsync/hsync/den/mono      per-tap syncs, data enable, mono flag (bit i = tap i)
//   tap_data                      per-tap {R,G,B}, tap i at [(i+1)*3*DW-1 : i*3*DW]
//   sel_req                       requested tap code
//   out_vsync/hsync/den, out_r/g/b  registered selected stream (1-cycle latency)
//   sel_active                    tap currently driving the outputs
//   switch_pending                a switch is waiting for the target's frame start
//   frame_cnt                     frame starts seen on the active tap since the last switch
module isp_tap_select
  import isp_pkg::*;
#(
  parameter int          NUM_TAPS    = 8,
  parameter int          DW          = 8,
  parameter int          SEL_W       = 4,
  parameter int          MUTE_FRAMES = 1,
  parameter logic [23:0] DEBUG_RGB   = DEBUG_RGB_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_TAPS-1:0]      tap_vsync,
  input  logic [NUM_TAPS-1:0]      tap_hsync,
  input  logic [NUM_TAPS-1:0]      tap_den,
  input  logic [NUM_TAPS*3*DW-1:0] tap_data,
  input  logic [NUM_TAPS-1:0]      tap_mono,
  input  logic [SEL_W-1:0]         sel_req,
  output logic                     out_vsync,
  output logic                     out_hsync,
  output logic                     out_den,
  output logic [DW-1:0]            out_r,
  output logic [DW-1:0]            out_g,
  output logic [DW-1:0]            out_b,
  output logic [SEL_W-1:0]         sel_active,
  output logic                     switch_pending,
  output logic [15:0]              frame_cnt
);

  // Each 8-bit field of DEBUG_RGB is zero-extended or truncated to DW.
  localparam logic [DW-1:0] DBG_R = DW'(DEBUG_RGB[23:16]);
  localparam logic [DW-1:0] DBG_G = DW'(DEBUG_RGB[15:8]);
  localparam logic [DW-1:0] DBG_B = DW'(DEBUG_RGB[7:0]);

  logic [NUM_TAPS-1:0] tap_fs;

  tap_state_t       state, state_nxt;
  logic [SEL_W-1:0] target, target_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [3:0]       mcnt, mcnt_nxt;
  logic             muted, muted_nxt;
  logic [15:0]      cnt_nxt;
  logic             active_fs, target_fs;

  logic             vs_nxt, hs_nxt, den_nxt;
  logic [DW-1:0]    r_nxt, g_nxt, b_nxt;
  logic [3*DW-1:0]  rgb_sel;
  logic             mono_sel;

  genvar g;
  generate
    for (g = 0; g < NUM_TAPS; g++) begin : g_edge
      isp_vsync_edge u_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .vsync      (tap_vsync[g]),
        .frame_start(tap_fs[g])
      );
    end
  endgenerate

  function automatic logic code_valid(input logic [SEL_W-1:0] code);
    return int'(code) < NUM_TAPS;
  endfunction

  // Invalid codes take their frame timing from the RAW tap.
  function automatic logic fs_of(input logic [SEL_W-1:0] code,
                                 input logic [NUM_TAPS-1:0] fs);
    logic hit;
    hit = fs[TAP_RAW];
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (int'(code) == i) hit = fs[i];
    end
    return hit;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      target     <= '0;
      sel_active <= '0;
      mcnt       <= '0;
      muted      <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      target     <= target_nxt;
      sel_active <= sel_nxt;
      mcnt       <= mcnt_nxt;
      muted      <= muted_nxt;
      frame_cnt  <= cnt_nxt;
    end
  end

  // Muting is tracked separately from the state so that a new request made
  // while muted keeps the output black through ARM until the switch lands.
  // In ARM a retarget outranks a same-cycle frame start of the old target.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    sel_nxt    = sel_active;
    mcnt_nxt   = mcnt;
    muted_nxt  = muted;
    active_fs  = fs_of(sel_active, tap_fs);
    target_fs  = fs_of(target, tap_fs);
    cnt_nxt    = active_fs ? frame_cnt + 16'd1 : frame_cnt;

    unique case (state)
      ST_RUN: begin
        if (sel_req != sel_active) begin
          state_nxt  = ST_ARM;
          target_nxt = sel_req;
        end
      end
      ST_ARM: begin
        if (sel_req == sel_active) begin
          state_nxt = ST_RUN;
          muted_nxt = 1'b0;
          mcnt_nxt  = '0;
        end else if (sel_req != target) begin
          target_nxt = sel_req;
        end else if (target_fs) begin
          sel_nxt = target;
          cnt_nxt = '0;
          if (MUTE_FRAMES > 0) begin
            state_nxt = ST_MUTE;
            mcnt_nxt  = 4'(MUTE_FRAMES);
            muted_nxt = 1'b1;
          end else begin
            state_nxt = ST_RUN;
            mcnt_nxt  = '0;
            muted_nxt = 1'b0;
          end
        end
      end
      ST_MUTE: begin
        if (sel_req != sel_active) begin
          state_nxt  = ST_ARM;
          target_nxt = sel_req;
        end else if (active_fs) begin
          if (mcnt <= 4'd1) begin
            state_nxt = ST_RUN;
            mcnt_nxt  = '0;
            muted_nxt = 1'b0;
          end else begin
            mcnt_nxt = mcnt - 4'd1;
          end
        end
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  // The output mux follows the next selection so the switch edge already
  // loads the new source's values.
  always_comb begin
    vs_nxt   = tap_vsync[TAP_RAW];
    hs_nxt   = tap_hsync[TAP_RAW];
    den_nxt  = tap_den[TAP_RAW];
    rgb_sel  = tap_data[TAP_RAW*3*DW +: 3*DW];
    mono_sel = tap_mono[TAP_RAW];
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (int'(sel_nxt) == i) begin
        vs_nxt   = tap_vsync[i];
        hs_nxt   = tap_hsync[i];
        den_nxt  = tap_den[i];
        rgb_sel  = tap_data[i*3*DW +: 3*DW];
        mono_sel = tap_mono[i];
      end
    end

    if (muted_nxt) begin
      r_nxt = '0;
      g_nxt = '0;
      b_nxt = '0;
    end else if (!code_valid(sel_nxt)) begin
      r_nxt = DBG_R;
      g_nxt = DBG_G;
      b_nxt = DBG_B;
    end else if (mono_sel) begin
      r_nxt = rgb_sel[3*DW-1 -: DW];
      g_nxt = rgb_sel[3*DW-1 -: DW];
      b_nxt = rgb_sel[3*DW-1 -: DW];
    end else begin
      r_nxt = rgb_sel[3*DW-1 -: DW];
      g_nxt = rgb_sel[2*DW-1 -: DW];
      b_nxt = rgb_sel[DW-1 -: DW];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vsync <= 1'b0;
      out_hsync <= 1'b0;
      out_den   <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
    end else begin
      out_vsync <= vs_nxt;
      out_hsync <= hs_nxt;
      out_den   <= den_nxt;
      out_r     <= r_nxt;
      out_g     <= g_nxt;
      out_b     <= b_nxt;
    end
  end

  assign switch_pending = (state == ST_ARM);

endmodule
